lzx_74hc259_dual: RTL and testbench
===================================

Name: lzx_74HC259_dual

Overview:
- Dual 1-to-4 addressable latch and demultiplexer, clocked. It is the receive end of the dual 4:1 mux path: a serial data bit per section plus a 2-bit address is written into one of four registered outputs.
- Supports manual addressing (S) or an internal auto-scan counter that walks addresses 0..3, so a muxed stream can be de-serialised back into parallel bits.
- Sits downstream of the lzx mux blocks in the gate-level chip library.

Parameters:
- AUTO_WRAP, 1, in auto-scan: 1 = counter wraps 3->0; 0 = counter stops at 3 and in_ready drops until restart.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- E1_n  input  1  section 1 enable, active low
- E2_n  input  1  section 2 enable, active low
- mode  input  2  00 latch, 01 demux, 10 hold, 11 clear
- auto  input  1  1 = address from internal scan counter; 0 = address from S
- restart  input  1  synchronous; scan counter to 0, clears the stopped condition
- S  input  2  manual address
- D1  input  1  section 1 serial data
- D2  input  1  section 2 serial data
- in_valid  input  1  a write is offered this cycle
- in_ready  output  1  the block accepts a write this cycle
- Q1  output  4  section 1 latched outputs
- Q2  output  4  section 2 latched outputs
- scan_addr  output  2  current scan counter value
- frame_done  output  1  one-cycle pulse after an accepted auto write to address 3

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Q1=0, Q2=0, scan_addr=0, frame_done=0, stopped flag=0.
  - in_ready then follows its combinational definition.
- Handshake:
  - in_ready = ~stopped & (mode != 2'b10).
  - A write is accepted when in_valid & in_ready at a rising clk edge.
  - Effective address A = auto ? scan_addr : S.
- Per section n (n=1,2), on an accepted write with En_n=0; all updates visible the cycle after the edge (latency 1):
  - mode 00 (latch): Qn[A] <= Dn; other Qn bits hold.
  - mode 01 (demux): Qn <= one-hot at A holding Dn; all other bits 0.
  - mode 11 (clear): Qn <= 0. Data and address are ignored, but the write still counts as accepted.
- Section with En_n=1: Qn holds in all modes.
- mode 10 (hold):
  - in_ready=0; no writes, no counter movement.
  - Q outputs hold.
- Scan counter: advances only on accepted writes with auto=1, with at least one section enabled and mode 00 or 01.
  - scan_addr 0->1->2->3.
  - At 3 with AUTO_WRAP=1: next value 0 and frame_done=1 next cycle.
  - At 3 with AUTO_WRAP=0: counter stays 3, stopped<=1, frame_done=1 next cycle.
- restart: scan_addr<=0 and stopped<=0 at the edge.
  - Priority over a counter advance in the same cycle.
  - The accepted data write in that same cycle still uses the pre-restart address.
- With auto=0, S drives the address and the counter holds.
- frame_done is registered and high for exactly one cycle per frame.
- Simultaneous E1_n=E2_n=0: both sections update from the same address and mode with their own D.
- Reset asserted mid-frame: all state clears immediately; the partially written frame is lost.

Test Plan:
- Reset check: rst_n=0 asynchronously mid-cycle -> Q1=Q2=4'h0, scan_addr=0, frame_done=0 before the next clk.
- Latch mode, manual: E1_n=0, E2_n=1, mode=00, auto=0; write S=0 D1=1, then S=2 D1=1, then S=0 D1=0 -> Q1 goes 0001, 0101, 0100; Q2 stays 0000.
- Demux mode: E1_n=E2_n=0, mode=01, S=3, D1=1, D2=0 -> Q1=1000, Q2=0000; next S=1, D2=1 -> Q2=0010.
- Auto scan with AUTO_WRAP=1: auto=1, mode=00, four accepted writes with D1 = 1,0,1,1 -> Q1=1101; frame_done pulses for one cycle after the 4th; scan_addr=0.
- AUTO_WRAP=0 stop and restart: after 4 accepted writes, in_ready=0 and scan_addr=3; assert restart -> in_ready=1, scan_addr=0.
- Hold and clear: mode=10 with in_valid=1 -> in_ready=0 and Q unchanged. Then mode=11 with E2_n=0, E1_n=1 -> Q2=0000 and Q1 unchanged.

Source files
------------

// File: rtl/lzx_74hc259_dual.sv
`default_nettype none
// ============================================================================
//  Module   : lzx_74hc259_dual
//  Purpose  : Dual clocked 1-to-4 addressable latch / demultiplexer with an
//             optional auto-scan address counter for de-serialising a muxed
//             stream back into parallel bits.
//  Revision : 1.0 - initial release
// ============================================================================
module lzx_74hc259_dual #(
  parameter bit AUTO_WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E1_n,
  input  logic       E2_n,
  input  logic [1:0] mode,
  input  logic       auto,
  input  logic       restart,
  input  logic [1:0] S,
  input  logic       D1,
  input  logic       D2,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [1:0] scan_addr,
  output logic       frame_done
);

  localparam logic [1:0] c_MODE_LATCH = 2'b00;
  localparam logic [1:0] c_MODE_DEMUX = 2'b01;
  localparam logic [1:0] c_MODE_HOLD  = 2'b10;
  localparam logic [1:0] c_MODE_CLEAR = 2'b11;
  localparam logic [1:0] c_LAST_ADDR  = 2'd3;

  logic [1:0] r_scan_addr;
  logic       r_stopped;
  logic       r_frame_done;
  logic [3:0] r_q [2];

  logic       w_in_ready;
  logic       w_accept;
  logic [1:0] w_addr;
  logic       w_any_enabled;
  logic       w_advance;
  logic       w_en_n [2];
  logic       w_d    [2];

  // Handshake, effective address and counter-advance qualification
  always_comb begin
    w_in_ready    = ~r_stopped & (mode != c_MODE_HOLD);
    w_accept      = in_valid & w_in_ready;
    w_addr        = auto ? r_scan_addr : S;
    w_any_enabled = ~E1_n | ~E2_n;
    // Only data-carrying modes (latch/demux) step the scan through a frame
    w_advance     = w_accept & auto & w_any_enabled &
                    ((mode == c_MODE_LATCH) | (mode == c_MODE_DEMUX));
  end

  // Map per-section inputs onto arrays so both sections share one body
  always_comb begin
    w_en_n[0] = E1_n;
    w_en_n[1] = E2_n;
    w_d[0]    = D1;
    w_d[1]    = D2;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_section
      logic [3:0] w_q_next;

      // Next value of this section's outputs for an accepted write
      always_comb begin
        w_q_next = r_q[gi];
        case (mode)
          c_MODE_LATCH: w_q_next[w_addr] = w_d[gi];
          c_MODE_DEMUX: w_q_next = {4{w_d[gi]}} & (4'b0001 << w_addr);
          c_MODE_CLEAR: w_q_next = 4'b0000;
          default:      w_q_next = r_q[gi];
        endcase
      end

      // Output register: updates only on an accepted write to an enabled section
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q[gi] <= 4'b0000;
        end else if (w_accept && !w_en_n[gi]) begin
          r_q[gi] <= w_q_next;
        end
      end
    end
  endgenerate

  // Scan counter and stop flag; restart wins over an advance in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_addr <= 2'd0;
      r_stopped   <= 1'b0;
    end else if (restart) begin
      r_scan_addr <= 2'd0;
      r_stopped   <= 1'b0;
    end else if (w_advance) begin
      if (r_scan_addr == c_LAST_ADDR) begin
        if (AUTO_WRAP) begin
          r_scan_addr <= 2'd0;
        end else begin
          r_stopped <= 1'b1;
        end
      end else begin
        r_scan_addr <= r_scan_addr + 2'd1;
      end
    end
  end

  // One-cycle end-of-frame pulse after the write to the last address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_advance && (r_scan_addr == c_LAST_ADDR);
    end
  end

  assign in_ready   = w_in_ready;
  assign Q1         = r_q[0];
  assign Q2         = r_q[1];
  assign scan_addr  = r_scan_addr;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lzx_74hc259_dual.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lzx_74hc259_dual
//  Purpose  : Directed bench for lzx_74hc259_dual; a wrapping and a stopping
//             instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lzx_74hc259_dual;

  logic       clk;
  logic       rst_n;
  logic       E1_n;
  logic       E2_n;
  logic [1:0] mode;
  logic       auto;
  logic       restart;
  logic [1:0] S;
  logic       D1;
  logic       D2;
  logic       in_valid;

  logic       w_rdy_w, w_rdy_s;
  logic [3:0] w_q1_w, w_q1_s, w_q2_w, w_q2_s;
  logic [1:0] w_sa_w, w_sa_s;
  logic       w_fd_w, w_fd_s;

  int n_tests;
  int n_fail;

  lzx_74hc259_dual #(.AUTO_WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .E1_n(E1_n), .E2_n(E2_n), .mode(mode),
    .auto(auto), .restart(restart), .S(S), .D1(D1), .D2(D2),
    .in_valid(in_valid), .in_ready(w_rdy_w), .Q1(w_q1_w), .Q2(w_q2_w),
    .scan_addr(w_sa_w), .frame_done(w_fd_w)
  );

  lzx_74hc259_dual #(.AUTO_WRAP(1'b0)) u_stop (
    .clk(clk), .rst_n(rst_n), .E1_n(E1_n), .E2_n(E2_n), .mode(mode),
    .auto(auto), .restart(restart), .S(S), .D1(D1), .D2(D2),
    .in_valid(in_valid), .in_ready(w_rdy_s), .Q1(w_q1_s), .Q2(w_q2_s),
    .scan_addr(w_sa_s), .frame_done(w_fd_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    E1_n     = 1'b1;
    E2_n     = 1'b1;
    mode     = 2'b10;
    auto     = 1'b0;
    restart  = 1'b0;
    S        = 2'd0;
    D1       = 1'b0;
    D2       = 1'b0;
    in_valid = 1'b0;
    #22;
    rst_n = 1'b1;

    // Load something, then assert reset mid-cycle
    E1_n = 1'b0; mode = 2'b00; S = 2'd1; D1 = 1'b1; in_valid = 1'b1;
    cyc();
    check("pre_reset_q1", {4'h0, w_q1_w}, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_q1",   {4'h0, w_q1_w}, 8'h00);
    check("rst_q2",   {4'h0, w_q2_w}, 8'h00);
    check("rst_scan", {6'h0, w_sa_w}, 8'h00);
    check("rst_fd",   {7'h0, w_fd_w}, 8'h00);
    check("rst_rdy",  {7'h0, w_rdy_s}, 8'h01);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    // Latch mode, manual addressing, section 1 only
    E1_n = 1'b0; E2_n = 1'b1; mode = 2'b00; auto = 1'b0; in_valid = 1'b1;
    S = 2'd0; D1 = 1'b1;
    cyc();
    check("latch_q1_a", {4'h0, w_q1_w}, 8'h01);
    S = 2'd2; D1 = 1'b1;
    cyc();
    check("latch_q1_b", {4'h0, w_q1_w}, 8'h05);
    S = 2'd0; D1 = 1'b0;
    cyc();
    check("latch_q1_c", {4'h0, w_q1_w}, 8'h04);
    check("latch_q2",   {4'h0, w_q2_w}, 8'h00);
    check("latch_scan", {6'h0, w_sa_w}, 8'h00);

    // Demux mode, both sections
    E1_n = 1'b0; E2_n = 1'b0; mode = 2'b01; S = 2'd3; D1 = 1'b1; D2 = 1'b0;
    cyc();
    check("demux_q1_a", {4'h0, w_q1_w}, 8'h08);
    check("demux_q2_a", {4'h0, w_q2_w}, 8'h00);
    S = 2'd1; D2 = 1'b1;
    cyc();
    check("demux_q1_b", {4'h0, w_q1_w}, 8'h02);
    check("demux_q2_b", {4'h0, w_q2_w}, 8'h02);

    // Clear both sections
    mode = 2'b11;
    cyc();
    check("clr_both_q1", {4'h0, w_q1_w}, 8'h00);
    check("clr_both_q2", {4'h0, w_q2_w}, 8'h00);

    // Auto scan: D1 = 1,0,1,1 into addresses 0..3
    E1_n = 1'b0; E2_n = 1'b1; mode = 2'b00; auto = 1'b1;
    D1 = 1'b1;
    cyc();
    check("auto1_q1",   {4'h0, w_q1_w}, 8'h01);
    check("auto1_scan", {6'h0, w_sa_w}, 8'h01);
    D1 = 1'b0;
    cyc();
    check("auto2_q1",   {4'h0, w_q1_w}, 8'h01);
    check("auto2_scan", {6'h0, w_sa_w}, 8'h02);
    D1 = 1'b1;
    cyc();
    check("auto3_q1",   {4'h0, w_q1_w}, 8'h05);
    check("auto3_scan", {6'h0, w_sa_w}, 8'h03);
    check("auto3_fd",   {7'h0, w_fd_w}, 8'h00);
    D1 = 1'b1;
    cyc();
    check("auto4_q1_w",   {4'h0, w_q1_w}, 8'h0D);
    check("auto4_q1_s",   {4'h0, w_q1_s}, 8'h0D);
    check("auto4_scan_w", {6'h0, w_sa_w}, 8'h00);
    check("auto4_scan_s", {6'h0, w_sa_s}, 8'h03);
    check("auto4_fd_w",   {7'h0, w_fd_w}, 8'h01);
    check("auto4_fd_s",   {7'h0, w_fd_s}, 8'h01);
    check("auto4_rdy_w",  {7'h0, w_rdy_w}, 8'h01);
    check("auto4_rdy_s",  {7'h0, w_rdy_s}, 8'h00);

    // Offered write: stopped instance refuses it, wrapping instance starts frame 2
    D1 = 1'b0;
    cyc();
    check("stopped_q1_s",   {4'h0, w_q1_s}, 8'h0D);
    check("stopped_scan_s", {6'h0, w_sa_s}, 8'h03);
    check("wrap_q1_w",      {4'h0, w_q1_w}, 8'h0C);
    check("wrap_scan_w",    {6'h0, w_sa_w}, 8'h01);
    check("fd_pulse_end_w", {7'h0, w_fd_w}, 8'h00);
    check("fd_pulse_end_s", {7'h0, w_fd_s}, 8'h00);

    // Restart clears the stop condition
    in_valid = 1'b0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_rdy_s",  {7'h0, w_rdy_s}, 8'h01);
    check("restart_scan_s", {6'h0, w_sa_s}, 8'h00);
    check("restart_scan_w", {6'h0, w_sa_w}, 8'h00);

    // Write to address 0, then a write with restart uses the pre-restart address 1
    in_valid = 1'b1; D1 = 1'b0;
    cyc();
    check("pre_rst_scan", {6'h0, w_sa_s}, 8'h01);
    check("pre_rst_q1",   {4'h0, w_q1_s}, 8'h0C);
    D1 = 1'b1; restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("rst_wr_q1_s",  {4'h0, w_q1_s}, 8'h0E);
    check("rst_wr_q1_w",  {4'h0, w_q1_w}, 8'h0E);
    check("rst_wr_scan",  {6'h0, w_sa_s}, 8'h00);

    // Hold: no handshake, nothing moves
    mode = 2'b10; D1 = 1'b0;
    #1;
    check("hold_rdy", {7'h0, w_rdy_w}, 8'h00);
    cyc();
    check("hold_q1",   {4'h0, w_q1_w}, 8'h0E);
    check("hold_scan", {6'h0, w_sa_w}, 8'h00);

    // Manual demux into section 2 only
    auto = 1'b0; mode = 2'b01; E1_n = 1'b1; E2_n = 1'b0; S = 2'd2; D2 = 1'b1;
    cyc();
    check("sec2_q2", {4'h0, w_q2_w}, 8'h04);
    check("sec2_q1", {4'h0, w_q1_w}, 8'h0E);

    // Clear section 2 only, in auto mode: counter must not move
    auto = 1'b1; mode = 2'b11;
    cyc();
    check("clr2_q2",   {4'h0, w_q2_w}, 8'h00);
    check("clr2_q1",   {4'h0, w_q1_w}, 8'h0E);
    check("clr2_scan", {6'h0, w_sa_w}, 8'h00);

    in_valid = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
